// File: rtl/mmm_bit_serial.sv
// Bit-serial Montgomery modular multiplier: r = A*B*2^-WIDTH mod M, one bit of A per enabled cycle.
// Define MMM_FINAL_SUB_EN to add the conditional final subtraction so r_out is fully reduced to [0, M).
module mmm_bit_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             rst_mmm,
  input  logic             ld_a,
  input  logic             ld_r,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ACC_W = WIDTH + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] a_sr;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W-1:0] addend_b;
  logic [ACC_W-1:0] t_sum;
  logic [ACC_W-1:0] addend_m;
  logic [ACC_W-1:0] t_red;
  logic [ACC_W-1:0] acc_step;
  logic [WIDTH-1:0] r_next;

`ifdef MMM_FINAL_SUB_EN
  // acc < 2M, so one conditional subtraction lands the result in [0, M).
  function automatic logic [WIDTH-1:0] final_reduce(input logic [ACC_W-1:0] acc_v,
                                                    input logic [WIDTH-1:0] m_v);
    logic [ACC_W-1:0] m_ext;
    logic [ACC_W-1:0] diff;
    m_ext = {2'b00, m_v};
    diff  = acc_v - m_ext;
    if (acc_v >= m_ext) return diff[WIDTH-1:0];
    else                return acc_v[WIDTH-1:0];
  endfunction
`else
  // Unreduced result in [0, 2M); only the low WIDTH bits are kept.
  function automatic logic [WIDTH-1:0] final_reduce(input logic [WIDTH-1:0] acc_v);
    return acc_v;
  endfunction
`endif

  // One Montgomery iteration: add B if the current multiplier bit is set,
  // then add M when needed to make the sum even before halving.
  always_comb begin
    addend_b = a_sr[0] ? {2'b00, b_in} : '0;
    t_sum    = acc + addend_b;
    addend_m = t_sum[0] ? {2'b00, m_in} : '0;
    t_red    = t_sum + addend_m;
    acc_step = t_red >> 1;
  end

  always_comb begin
`ifdef MMM_FINAL_SUB_EN
    r_next = final_reduce(acc, m_in);
`else
    r_next = final_reduce(acc[WIDTH-1:0]);
`endif
  end

  // Result capture works off the pre-update accumulator, independent of the control chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (ena && ld_r) begin
      r_out <= r_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (ena) begin
      if (!rst_mmm) begin
        acc  <= '0;
        cnt  <= '0;
        busy <= 1'b0;
        done <= 1'b0;
      end else if (ld_a) begin
        a_sr <= a_in;
        acc  <= '0;
        cnt  <= '0;
        busy <= 1'b1;
        done <= 1'b0;
      end else if (busy) begin
        acc  <= acc_step;
        a_sr <= a_sr >> 1;
        cnt  <= cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmm_bit_serial.sv
// Self-checking bench for mmm_bit_serial (WIDTH=8); reference computes the Montgomery product arithmetically.
module tb_mmm_bit_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b1;
  logic         rst_mmm = 1'b1;
  logic         ld_a = 1'b0;
  logic         ld_r = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [W-1:0] m_in = 8'd13;
  logic [W-1:0] r_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  mmm_bit_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .rst_mmm(rst_mmm), .ld_a(ld_a), .ld_r(ld_r),
    .a_in(a_in), .b_in(b_in), .m_in(m_in), .r_out(r_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Montgomery product: find Q < 2^W with A*B + Q*M divisible by 2^W, result = (A*B+Q*M)/2^W.
  function automatic int mont_ref(input int a, input int b, input int m);
    int ab, q, raw;
    ab = a * b;
    q = 0;
    for (int k = 0; k < (1 << W); k++) begin
      if (((ab + k * m) % (1 << W)) == 0) begin
        q = k;
        break;
      end
    end
    raw = (ab + q * m) / (1 << W);
`ifdef MMM_FINAL_SUB_EN
    return (raw >= m) ? raw - m : raw;
`else
    return raw % (1 << W);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int a, input int b, input int m);
    a_in = W'(a); b_in = W'(b); m_in = W'(m);
    ld_a = 1'b1;
    tick();
    ld_a = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit ok);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    ok = done;
  endtask

  task automatic capture();
    ld_r = 1'b1;
    tick();
    ld_r = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    tick();
    checks++;
    if (r_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: r_out=%0d busy=%0b done=%0b, want 0 0 0", r_out, busy, done);
    end
  endtask

  task automatic test_known();
    int n, exp_r, busy_cnt;
    bit ok;
    exp_r = mont_ref(9, 5, 13);
    start_op(9, 5, 13);
    busy_cnt = 0;
    n = 0;
    while (!done && n < 200) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    ok = done;
    checks++;
    if (!ok || n != 8) begin
      errors++;
      $display("FAIL known_latency: done after %0d cycles (done=%0b), want 8", n, done);
    end
    checks++;
    if (busy_cnt != 8 || busy !== 1'b0) begin
      errors++;
      $display("FAIL known_busy: busy cycles %0d busy=%0b, want 8 and 0", busy_cnt, busy);
    end
    capture();
    checks++;
    if (int'(r_out) != exp_r) begin
      errors++;
      $display("FAIL known_result: r_out=%0d, want %0d", r_out, exp_r);
    end
`ifdef MMM_FINAL_SUB_EN
    checks++;
    if (r_out !== 8'd5) begin
      errors++;
      $display("FAIL known_const: r_out=%0d, want 5", r_out);
    end
`endif
    tick(); tick();
    capture();
    checks++;
    if (int'(r_out) != exp_r || done !== 1'b1) begin
      errors++;
      $display("FAIL repeat_ldr: r_out=%0d done=%0b, want %0d 1", r_out, done, exp_r);
    end
  endtask

  task automatic test_one();
    int n;
    bit ok;
    start_op(1, 1, 13);
    wait_done(n, ok);
    capture();
    checks++;
    if (!ok || (int'(r_out) % 13) != 3 || int'(r_out) >= 26) begin
      errors++;
      $display("FAIL one_congruent: r_out=%0d done=%0b, want r_out mod 13 = 3 and < 26", r_out, ok);
    end
    checks++;
    if (int'(r_out) != mont_ref(1, 1, 13)) begin
      errors++;
      $display("FAIL one_exact: r_out=%0d, want %0d", r_out, mont_ref(1, 1, 13));
    end
  endtask

  task automatic test_ena_stall();
    int n;
    bit ok;
    logic [W-1:0] r_hold;
    logic b_hold, d_hold;
    start_op(9, 5, 13);
    tick(); tick(); tick();
    ena = 1'b0;
    ld_r = 1'b1;
    r_hold = r_out; b_hold = busy; d_hold = done;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (r_out !== r_hold || busy !== b_hold || done !== d_hold) begin
        errors++;
        $display("FAIL stall_hold: r=%0d b=%0b d=%0b, want %0d %0b %0d", r_out, busy, done, r_hold, b_hold, d_hold);
      end
    end
    ld_r = 1'b0;
    ena = 1'b1;
    wait_done(n, ok);
    checks++;
    if (!ok || 3 + 5 + n != 13) begin
      errors++;
      $display("FAIL stall_latency: done after %0d cycles, want 13", 3 + 5 + n);
    end
    capture();
    checks++;
    if (int'(r_out) != mont_ref(9, 5, 13)) begin
      errors++;
      $display("FAIL stall_result: r_out=%0d, want %0d", r_out, mont_ref(9, 5, 13));
    end
  endtask

  task automatic test_clear();
    int n;
    bit ok;
    logic [W-1:0] r_prev;
    r_prev = r_out;
    start_op(9, 5, 13);
    tick(); tick(); tick(); tick();
    rst_mmm = 1'b0;
    tick();
    rst_mmm = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || r_out !== r_prev) begin
      errors++;
      $display("FAIL clear: busy=%0b done=%0b r_out=%0d, want 0 0 %0d", busy, done, r_out, r_prev);
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle: busy=%0b done=%0b, want 0 0", busy, done);
    end
    start_op(0, 7, 13);
    wait_done(n, ok);
    capture();
    checks++;
    if (!ok || r_out !== '0) begin
      errors++;
      $display("FAIL clear_zero: r_out=%0d done=%0b, want 0 1", r_out, ok);
    end
  endtask

  task automatic test_ldr_lda();
    int n;
    bit ok;
    start_op(9, 5, 13);
    wait_done(n, ok);
    a_in = 8'd1; b_in = 8'd1; m_in = 8'd13;
    ld_a = 1'b1; ld_r = 1'b1;
    tick();
    ld_a = 1'b0; ld_r = 1'b0;
    checks++;
    if (int'(r_out) != mont_ref(9, 5, 13) || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL ldr_lda: r_out=%0d busy=%0b done=%0b, want %0d 1 0", r_out, busy, done, mont_ref(9, 5, 13));
    end
    wait_done(n, ok);
    capture();
    checks++;
    if (!ok || int'(r_out) != mont_ref(1, 1, 13)) begin
      errors++;
      $display("FAIL ldr_lda_next: r_out=%0d, want %0d", r_out, mont_ref(1, 1, 13));
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    start_op(11, 4, 13);
    tick(); tick(); tick();
    start_op(7, 12, 13);
    wait_done(n, ok);
    checks++;
    if (!ok || n != 8) begin
      errors++;
      $display("FAIL restart_latency: done after %0d cycles, want 8", n);
    end
    capture();
    checks++;
    if (int'(r_out) != mont_ref(7, 12, 13)) begin
      errors++;
      $display("FAIL restart_result: r_out=%0d, want %0d", r_out, mont_ref(7, 12, 13));
    end
  endtask

  task automatic test_async_rst();
    int n;
    bit ok;
    start_op(9, 5, 13);
    tick(); tick(); tick();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (r_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: r_out=%0d busy=%0b done=%0b, want 0 0 0", r_out, busy, done);
    end
    #2 rst = 1'b0;
    tick();
    start_op(9, 5, 13);
    wait_done(n, ok);
    capture();
    checks++;
    if (!ok || n != 8 || int'(r_out) != mont_ref(9, 5, 13)) begin
      errors++;
      $display("FAIL async_rst_after: r_out=%0d cycles=%0d, want %0d 8", r_out, n, mont_ref(9, 5, 13));
    end
  endtask

  task automatic test_random();
    int a, b, m, n, exp_r;
    for (int i = 0; i < 24; i++) begin
      m = 2 * $urandom_range(1, 63) + 1;
      a = $urandom_range(0, m - 1);
      b = $urandom_range(0, m - 1);
      exp_r = mont_ref(a, b, m);
      start_op(a, b, m);
      n = 0;
      while (!done && n < 400) begin
        ena = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      ena = 1'b1;
      capture();
      checks++;
      if (done !== 1'b1 || int'(r_out) != exp_r) begin
        errors++;
        $display("FAIL random: A=%0d B=%0d M=%0d r_out=%0d done=%0b, want %0d", a, b, m, r_out, done, exp_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_one();
    test_ena_stall();
    test_clear();
    test_ldr_lda();
    test_back_to_back();
    test_async_rst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
